// File: rtl/cache_bus_arbiter.sv
// Cache bus arbiter: shares one downstream cache bus between MASTER_CNT requesters.
// Round-robin by default; define CACHE_BUS_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
package cache_bus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  burst_size;
    logic [1:0]  data_size;
    logic        cached;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  data_strobe;
    logic        data_ok;
    logic        data_last;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] r_data;
    logic        data_ok;
    logic        data_last;
  } cache_bus_resp_t;
endpackage

module cache_bus_arb_port
  import cache_bus_pkg::*;
(
  input  logic            sel,
  input  cache_bus_resp_t bus_resp,
  output cache_bus_resp_t resp
);
  assign resp = sel ? bus_resp : '0;
endmodule

module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int MASTER_CNT = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  cache_bus_req_t  [MASTER_CNT-1:0] m_req_i,
  output cache_bus_resp_t [MASTER_CNT-1:0] m_resp_o,
  output cache_bus_req_t                   bus_req_o,
  input  cache_bus_resp_t                  bus_resp_i,
  output logic [MASTER_CNT-1:0]            grant_o,
  output logic                             busy_o
);
  localparam int IDXW = $clog2(MASTER_CNT);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADDR = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t                state_q, state_d;
  logic [MASTER_CNT-1:0] grant_q, grant_d;
  logic [IDXW-1:0]       gidx_q, gidx_d, win;
  logic [MASTER_CNT-1:0] req_vld;

  // grant_q is zero outside ADDR/DATA, so it alone gates each response path
  for (genvar k = 0; k < MASTER_CNT; k++) begin : g_port
    assign req_vld[k] = m_req_i[k].valid;
    cache_bus_arb_port u_port (
      .sel      (grant_q[k]),
      .bus_resp (bus_resp_i),
      .resp     (m_resp_o[k])
    );
  end

`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = MASTER_CNT - 1; i >= 0; i--)
      if (req_vld[i]) win = IDXW'(i);
  end
`else
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < MASTER_CNT; i++) begin : scan
      int j;
      j = int'(ptr_q) + i;
      if (j >= MASTER_CNT) j = j - MASTER_CNT;
      if (!found && req_vld[j]) begin
        found = 1'b1;
        win   = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    bus_req_o = '0;
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_vld) begin
          state_d = ADDR;
          gidx_d  = win;
          grant_d = MASTER_CNT'(1) << win;
        end
      end
      ADDR: begin
        bus_req_o = m_req_i[gidx_q];
        // withdrawn request aborts without touching the pointer
        if (!m_req_i[gidx_q].valid) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (bus_resp_i.ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        bus_req_o       = m_req_i[gidx_q];
        bus_req_o.valid = 1'b0;
        if (bus_resp_i.data_ok && bus_resp_i.data_last) begin
          state_d = IDLE;
          grant_d = '0;
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
          ptr_d   = (gidx_q == IDXW'(MASTER_CNT - 1)) ? '0 : gidx_q + IDXW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter with two masters; expectations follow the
// build (round-robin default, fixed priority with CACHE_BUS_ARB_FIXED_PRIO_EN).
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  cache_bus_req_t  [1:0] m_req;
  cache_bus_resp_t [1:0] m_resp;
  cache_bus_req_t        bus_req;
  cache_bus_resp_t       bus_resp;
  logic [1:0]            grant;
  logic                  busy;
  int                    errors = 0;
  int                    checks = 0;

  cache_bus_arbiter #(.MASTER_CNT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (m_req),
    .m_resp_o   (m_resp),
    .bus_req_o  (bus_req),
    .bus_resp_i (bus_resp),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    m_req = '0;
    m_req[0].valid = 1'b1;
    bus_resp = '0;
    bus_resp.data_ok = 1'b1;
    rst = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL reset_bus_req got=%h want=0", bus_req); end
    checks++; if (m_resp !== '0) begin errors++; $display("FAIL reset_m_resp got=%h want=0", m_resp); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b want=00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    m_req = '0;
    bus_resp = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    m_req[0].valid = 1'b1;
    m_req[0].cached = 1'b1;
    m_req[0].burst_size = 4'b0011;
    m_req[0].addr = 32'h1C000040;
    #1;
    checks++; if (bus_req.valid !== 1'b0) begin errors++; $display("FAIL sr_valid_same_cycle got=%b want=0", bus_req.valid); end
    tick();
    checks++; if (bus_req.valid !== 1'b1) begin errors++; $display("FAIL sr_valid_next_cycle got=%b want=1", bus_req.valid); end
    checks++; if (bus_req.addr !== 32'h1C000040) begin errors++; $display("FAIL sr_addr got=%h want=1c000040", bus_req.addr); end
    checks++; if (bus_req.burst_size !== 4'b0011) begin errors++; $display("FAIL sr_burst got=%h want=3", bus_req.burst_size); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sr_grant got=%b want=01", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy got=%b want=1", busy); end
    tick();
    checks++; if (bus_req.valid !== 1'b1) begin errors++; $display("FAIL sr_addr_hold got=%b want=1", bus_req.valid); end
    bus_resp.ready = 1'b1;
    #1;
    checks++; if (m_resp[0].ready !== 1'b1) begin errors++; $display("FAIL sr_ready_m0 got=%b want=1", m_resp[0].ready); end
    checks++; if (m_resp[1] !== '0) begin errors++; $display("FAIL sr_ready_m1 got=%h want=0", m_resp[1]); end
    tick();
    bus_resp.ready = 1'b0;
    m_req[0].valid = 1'b0;
    #1;
    checks++; if (bus_req.valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sr_data_phase valid=%b busy=%b want 0/1", bus_req.valid, busy); end
    for (int i = 0; i < 4; i++) begin
      bus_resp.data_ok = 1'b1;
      bus_resp.r_data = 32'hA0 + i;
      bus_resp.data_last = (i == 3);
      #1;
      checks++; if (m_resp[0].r_data !== 32'hA0 + i || m_resp[0].data_ok !== 1'b1) begin errors++; $display("FAIL sr_beat%0d r_data=%h ok=%b want %h/1", i, m_resp[0].r_data, m_resp[0].data_ok, 32'hA0 + i); end
      checks++; if (m_resp[1] !== '0) begin errors++; $display("FAIL sr_beat%0d_m1 got=%h want=0", i, m_resp[1]); end
      tick();
    end
    bus_resp = '0;
    m_req = '0;
    #1;
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL sr_end busy=%b grant=%b want 0/00", busy, grant); end
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL sr_end_bus_req got=%h want=0", bus_req); end
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp [4];
`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
    exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    m_req = '0;
    m_req[0].valid = 1'b1; m_req[0].addr = 32'h00001000;
    m_req[1].valid = 1'b1; m_req[1].addr = 32'h00002000;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (grant !== exp[n]) begin errors++; $display("FAIL sim_grant%0d got=%b want=%b", n, grant, exp[n]); end
      bus_resp.ready = 1'b1;
      tick();
      bus_resp.ready = 1'b0;
      bus_resp.data_ok = 1'b1;
      bus_resp.data_last = 1'b1;
      tick();
      bus_resp = '0;
      #1;
      checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL sim_idle%0d busy=%b grant=%b want 0/00", n, busy, grant); end
    end
    m_req = '0;
    tick();
  endtask

  task automatic test_uncached;
    m_req[1].valid = 1'b1;
    m_req[1].addr = 32'h1FD00004;
    m_req[1].burst_size = 4'b0000;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL unc_grant got=%b want=10", grant); end
    checks++; if (bus_req.addr !== 32'h1FD00004 || bus_req.valid !== 1'b1) begin errors++; $display("FAIL unc_bus_req addr=%h valid=%b want 1fd00004/1", bus_req.addr, bus_req.valid); end
    bus_resp.ready = 1'b1;
    tick();
    bus_resp.ready = 1'b0;
    m_req[1].valid = 1'b0;
    bus_resp.data_ok = 1'b1;
    bus_resp.data_last = 1'b1;
    bus_resp.r_data = 32'h5555AAAA;
    #1;
    checks++; if (m_resp[1].r_data !== 32'h5555AAAA || m_resp[1].data_last !== 1'b1) begin errors++; $display("FAIL unc_beat r_data=%h last=%b want 5555aaaa/1", m_resp[1].r_data, m_resp[1].data_last); end
    tick();
    bus_resp = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unc_idle busy=%b want=0", busy); end
    // pointer back at 0: a simultaneous pair must go to master 0
    m_req[0].valid = 1'b1;
    m_req[1].valid = 1'b1;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL unc_ptr0 got=%b want=01", grant); end
    bus_resp.ready = 1'b1;
    tick();
    bus_resp.ready = 1'b0;
    m_req = '0;
    bus_resp.data_ok = 1'b1;
    bus_resp.data_last = 1'b1;
    tick();
    bus_resp = '0;
  endtask

  task automatic test_abort;
    logic [1:0] exp_regrant;
`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
    exp_regrant = 2'b01;
`else
    exp_regrant = 2'b10;
`endif
    m_req[1].valid = 1'b1;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_grant got=%b want=10", grant); end
    m_req[1].valid = 1'b0;
    #1;
    checks++; if (bus_req.valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", bus_req.valid); end
    tick();
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL abort_idle busy=%b grant=%b want 0/00", busy, grant); end
    m_req[0].valid = 1'b1;
    m_req[1].valid = 1'b1;
    tick();
    checks++; if (grant !== exp_regrant) begin errors++; $display("FAIL abort_regrant got=%b want=%b", grant, exp_regrant); end
    m_req = '0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_drop busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_data;
    m_req[1].valid = 1'b1;
    tick();
    bus_resp.ready = 1'b1;
    tick();
    bus_resp.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_resp.data_ok = 1'b1;
      bus_resp.r_data = 32'hB0 + i;
      tick();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state grant=%b busy=%b want 00/0", grant, busy); end
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL rst_mid_bus_req got=%h want=0", bus_req); end
    checks++; if (m_resp !== '0) begin errors++; $display("FAIL rst_mid_m_resp got=%h want=0", m_resp); end
    m_req[0].valid = 1'b1;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_mid_ptr got=%b want=01", grant); end
    m_req = '0;
    bus_resp = '0;
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    m_req = '0;
    bus_resp = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_uncached();
    test_abort();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
